sample_window_counter: RTL and testbench

//  Parametrised successor to the fixed 1000-sample counter.
//  - Counts cnt_up strobes into a runtime-programmable window, in continuous or one-shot mode.
//  - Reports each completed window and keeps a saturating count of completed windows.
//  - Flags strobes lost while a one-shot window waits to be collected.
//  - Sits between the sample front end (cnt_up source) and the controller that drains results.

---
 rtl/sample_window_counter.sv | 143 ++++++++++++++
 tb/tb_sample_window_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_window_counter.sv
// Sample window counter: counts cnt_up strobes into a programmable window,
// in continuous or one-shot mode, with window tally and overrun flag.
module sample_window_counter #(
    parameter int CNT_BITS       = 16,
    parameter int WIN_BITS       = 8,
    parameter int DEFAULT_WINDOW = 1000
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                start,
    input  logic                one_shot,
    input  logic [CNT_BITS-1:0] window_len,
    input  logic                cnt_up,
    output logic [CNT_BITS-1:0] count_out,
    output logic                window_done,
    output logic                done_hold,
    output logic                busy,
    output logic [WIN_BITS-1:0] win_count,
    output logic                overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] DEF_LEN = CNT_BITS'(DEFAULT_WINDOW);
    localparam logic [CNT_BITS-1:0] ONE     = CNT_BITS'(1);
    localparam logic [WIN_BITS-1:0] WIN_ONE = WIN_BITS'(1);
    localparam logic [WIN_BITS-1:0] WIN_MAX = '1;

    state_t              state;
    state_t              state_nx;
    logic [CNT_BITS-1:0] len_q;
    logic [CNT_BITS-1:0] len_nx;
    logic [CNT_BITS-1:0] len_sel;
    logic                mode_q;
    logic                mode_nx;
    logic [CNT_BITS-1:0] count_nx;
    logic [WIN_BITS-1:0] win_nx;
    logic                ovr_nx;
    logic                done_nx;
    logic                hit_last;
    logic                hit_full;
    logic                complete;

    assign len_sel  = (window_len == '0) ? DEF_LEN : window_len;
    assign hit_last = (count_out == len_q - ONE);
    assign hit_full = (count_out == len_q);
    // A length-1 window completes again on every strobe once full.
    assign complete = (state == RUN) && cnt_up &&
                      (hit_last || (hit_full && len_q == ONE));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nx = RUN;
                RUN:     if (complete && mode_q) state_nx = HOLD;
                HOLD:    if (start) state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        count_nx = count_out;
        win_nx   = win_count;
        ovr_nx   = overrun;
        done_nx  = 1'b0;
        len_nx   = len_q;
        mode_nx  = mode_q;
        if (clear) begin
            count_nx = '0;
            win_nx   = '0;
            ovr_nx   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_nx   = len_sel;
                        mode_nx  = one_shot;
                        count_nx = '0;
                    end
                end
                RUN: begin
                    if (complete) begin
                        count_nx = len_q;
                        done_nx  = 1'b1;
                        if (win_count != WIN_MAX) win_nx = win_count + WIN_ONE;
                    end else if (cnt_up && hit_full) begin
                        count_nx = ONE;
                    end else if (cnt_up) begin
                        count_nx = count_out + ONE;
                    end
                end
                HOLD: begin
                    if (cnt_up) ovr_nx = 1'b1;
                    if (start) begin
                        len_nx   = len_sel;
                        mode_nx  = one_shot;
                        count_nx = '0;
                    end
                end
                default: count_nx = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out   <= '0;
            win_count   <= '0;
            overrun     <= 1'b0;
            window_done <= 1'b0;
            len_q       <= DEF_LEN;
            mode_q      <= 1'b0;
        end else begin
            count_out   <= count_nx;
            win_count   <= win_nx;
            overrun     <= ovr_nx;
            window_done <= done_nx;
            len_q       <= len_nx;
            mode_q      <= mode_nx;
        end
    end

    assign busy      = (state == RUN);
    assign done_hold = (state == HOLD);

endmodule

// File: tb/tb_sample_window_counter.sv
// Bench for sample_window_counter: window-level model checked every cycle
// plus literal expectations from directed scenarios.
module tb_sample_window_counter;

    localparam int CB   = 16;
    localparam int WB   = 2;
    localparam int DW   = 1000;
    localparam int WMAX = (1 << WB) - 1;

    logic          clk;
    logic          n_rst;
    logic          clear;
    logic          start;
    logic          one_shot;
    logic [CB-1:0] window_len;
    logic          cnt_up;
    logic [CB-1:0] count_out;
    logic          window_done;
    logic          done_hold;
    logic          busy;
    logic [WB-1:0] win_count;
    logic          overrun;

    int total;
    int bad;
    int pulses;

    // model: phase 0 idle, 1 run, 2 hold; k strobes counted since start
    int m_ph;
    int m_k;
    int m_n;
    int m_os;
    int m_win;
    int m_ovr;
    int m_done;

    sample_window_counter #(
        .CNT_BITS(CB),
        .WIN_BITS(WB),
        .DEFAULT_WINDOW(DW)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .clear(clear),
        .start(start),
        .one_shot(one_shot),
        .window_len(window_len),
        .cnt_up(cnt_up),
        .count_out(count_out),
        .window_done(window_done),
        .done_hold(done_hold),
        .busy(busy),
        .win_count(win_count),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endfunction

    function automatic int exp_cnt();
        if (m_ph == 0 || m_k == 0) return 0;
        return ((m_k - 1) % m_n) + 1;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_ph = 0; m_k = 0; m_n = DW; m_os = 0;
            m_win = 0; m_ovr = 0; m_done = 0;
        end else if (clear) begin
            m_ph = 0; m_k = 0; m_win = 0; m_ovr = 0; m_done = 0;
        end else begin
            m_done = 0;
            case (m_ph)
                0: if (start) begin
                    m_n = (window_len == 0) ? DW : int'(window_len);
                    m_os = int'(one_shot); m_k = 0; m_ph = 1;
                end
                1: if (cnt_up) begin
                    m_k++;
                    if (m_k % m_n == 0) begin
                        m_done = 1;
                        if (m_win < WMAX) m_win++;
                        if (m_os != 0) m_ph = 2;
                    end
                end
                default: begin
                    if (cnt_up) m_ovr = 1;
                    if (start) begin
                        m_n = (window_len == 0) ? DW : int'(window_len);
                        m_os = int'(one_shot); m_k = 0; m_ph = 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("count", int'(count_out), exp_cnt());
        chk("done", int'(window_done), m_done);
        chk("busy", int'(busy), int'(m_ph == 1));
        chk("hold", int'(done_hold), int'(m_ph == 2));
        chk("wins", int'(win_count), m_win);
        chk("ovr", int'(overrun), m_ovr);
        if (window_done) pulses++;
    end

    task automatic drive(input logic c, input logic s, input logic o,
                         input int l, input logic u);
        @(negedge clk);
        #1;
        clear = c; start = s; one_shot = o;
        window_len = CB'(l); cnt_up = u;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic ups(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1);
    endtask

    task automatic do_clear();
        drive(1, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        total = 0; bad = 0; pulses = 0;
        n_rst = 1'b0; clear = 0; start = 0; one_shot = 0;
        window_len = '0; cnt_up = 0;
        #2;
        chk("rst_count", int'(count_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wins", int'(win_count), 0);
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;

        // one-shot window of 4
        drive(0, 1, 1, 4, 0);
        ups(4);
        idle();
        chk("t1_count", int'(count_out), 4);
        chk("t1_done", int'(window_done), 1);
        idle();
        chk("t1_hold", int'(done_hold), 1);
        chk("t1_busy", int'(busy), 0);
        chk("t1_wins", int'(win_count), 1);

        // continuous window of 3; mid-run start and len changes ignored
        do_clear();
        drive(0, 1, 0, 3, 0);
        pulses = 0;
        ups(3);
        drive(0, 1, 1, 9, 1);
        drive(0, 0, 1, 7, 1);
        ups(2);
        idle();
        chk("t2_count", int'(count_out), 1);
        chk("t2_wins", int'(win_count), 2);
        chk("t2_busy", int'(busy), 1);
        idle();
        chk("t2_pulses", pulses, 2);

        // default window length
        do_clear();
        drive(0, 1, 1, 0, 0);
        pulses = 0;
        ups(999);
        idle();
        chk("t3_count999", int'(count_out), 999);
        chk("t3_nopulse", pulses, 0);
        ups(1);
        idle();
        chk("t3_count", int'(count_out), 1000);
        chk("t3_done", int'(window_done), 1);
        idle();
        chk("t3_pulses", pulses, 1);

        // overrun while holding, kept across restart
        do_clear();
        drive(0, 1, 1, 2, 0);
        ups(2);
        idle();
        idle();
        chk("t4_hold", int'(done_hold), 1);
        ups(2);
        idle();
        chk("t4_ovr", int'(overrun), 1);
        chk("t4_count", int'(count_out), 2);
        drive(0, 1, 0, 5, 0);
        idle();
        chk("t4_rcount", int'(count_out), 0);
        chk("t4_rbusy", int'(busy), 1);
        chk("t4_rovr", int'(overrun), 1);

        // length 1 continuous; tally saturates
        do_clear();
        drive(0, 1, 0, 1, 0);
        pulses = 0;
        ups(6);
        idle();
        idle();
        chk("t5_pulses", pulses, 6);
        chk("t5_wins", int'(win_count), 3);
        chk("t5_count", int'(count_out), 1);

        // clear wins over start and completion
        do_clear();
        drive(0, 1, 0, 2, 0);
        ups(3);
        drive(1, 1, 0, 2, 1);
        idle();
        chk("t6_count", int'(count_out), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_wins", int'(win_count), 0);
        chk("t6_done", int'(window_done), 0);

        // async reset mid-window
        drive(0, 1, 0, 2, 0);
        ups(3);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("t6r_count", int'(count_out), 0);
        chk("t6r_wins", int'(win_count), 0);
        chk("t6r_busy", int'(busy), 0);
        chk("t6r_done", int'(window_done), 0);
        @(negedge clk);
        #1;
        n_rst = 1'b1; cnt_up = 0; start = 0;
        idle();
        idle();
        chk("t6r_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
